// File: rtl/torgb_mul_arb_pkg.sv
// Shared widths, tag-width helper and the tag/valid pipeline stage type
// for the YUV->RGB shared multiplier arbiter.
package torgb_mul_arb_pkg;

    localparam int A_WIDTH_DEF = 32;
    localparam int B_WIDTH_DEF = 34;
    localparam int P_WIDTH_DEF = 65;
    localparam int TAG_MAX_W   = 3;   // enough for up to 8 requesters

    function automatic int tag_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                 vld;
        logic [TAG_MAX_W-1:0] tag;
    } stage_t;

endpackage

// File: rtl/torgb_mul_pipe.sv
// MUL_STAGES-deep signed x unsigned multiplier; data registers carry no reset
// and advance only on ce.
module torgb_mul_pipe #(
    parameter int A_WIDTH    = 32,
    parameter int B_WIDTH    = 34,
    parameter int P_WIDTH    = 65,
    parameter int MUL_STAGES = 1
) (
    input  logic               clk,
    input  logic               ce,
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    output logic [P_WIDTH-1:0] p
);

    // Extending both operands to P_WIDTH keeps the low P_WIDTH bits exact
    // without carrying unused upper product bits.
    logic [P_WIDTH-1:0] ax, bx, prod;
    logic [P_WIDTH-1:0] pr [MUL_STAGES];

    assign ax   = {{(P_WIDTH-A_WIDTH){a[A_WIDTH-1]}}, a};
    assign bx   = {{(P_WIDTH-B_WIDTH){1'b0}}, b};
    assign prod = ax * bx;

    always_ff @(posedge clk) begin
        if (ce) begin
            pr[0] <= prod;
            for (int i = 1; i < MUL_STAGES; i++) pr[i] <= pr[i-1];
        end
    end

    assign p = pr[MUL_STAGES-1];

endmodule

// File: rtl/torgb_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier between NUM_REQ
// requesters; a tag pipeline routes each product back to its issuer.
module torgb_mul_arbiter
    import torgb_mul_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int A_WIDTH    = A_WIDTH_DEF,
    parameter int B_WIDTH    = B_WIDTH_DEF,
    parameter int P_WIDTH    = P_WIDTH_DEF,
    parameter int MUL_STAGES = 1,
    parameter int TAG_W      = tag_w(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [TAG_W-1:0]           res_tag,
    output logic [P_WIDTH-1:0]         res_data,
    output logic                       idle,
    output logic [31:0]                op_count
);

    function automatic logic [TAG_W-1:0] wrap_add(input logic [TAG_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) s -= NUM_REQ;
        return TAG_W'(s);
    endfunction

    logic                ce;
    logic [TAG_W-1:0]    rr_ptr;
    logic [NUM_REQ-1:0]  gnt;
    logic [TAG_W-1:0]    gnt_idx;
    logic                gnt_any;
    logic [A_WIDTH-1:0]  a_sel;
    logic [B_WIDTH-1:0]  b_sel;
    stage_t              stg_in;
    stage_t              stg_pipe [MUL_STAGES];
    stage_t              stg_out;
    logic                unused_tag_hi;

    assign ce = ~res_valid | res_ready;

    // Scan from the farthest candidate down so the one nearest rr_ptr wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            if (req_valid[wrap_add(rr_ptr, k)]) begin
                gnt                      = '0;
                gnt[wrap_add(rr_ptr, k)] = 1'b1;
                gnt_idx                  = wrap_add(rr_ptr, k);
            end
        end
        if (!ce) begin
            gnt     = '0;
            gnt_idx = '0;
        end
    end

    assign gnt_any   = |gnt;
    assign req_ready = gnt;
    assign a_sel     = req_a[int'(gnt_idx)*A_WIDTH +: A_WIDTH];
    assign b_sel     = req_b[int'(gnt_idx)*B_WIDTH +: B_WIDTH];
    assign stg_in    = '{vld: gnt_any, tag: TAG_MAX_W'(gnt_idx)};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MUL_STAGES; i++) stg_pipe[i] <= '0;
            rr_ptr   <= '0;
            op_count <= '0;
        end else begin
            if (ce) begin
                stg_pipe[0] <= stg_in;
                for (int i = 1; i < MUL_STAGES; i++) stg_pipe[i] <= stg_pipe[i-1];
            end
            if (gnt_any) begin
                rr_ptr   <= wrap_add(gnt_idx, 1);
                op_count <= op_count + 32'd1;
            end
        end
    end

    torgb_mul_pipe #(
        .A_WIDTH    (A_WIDTH),
        .B_WIDTH    (B_WIDTH),
        .P_WIDTH    (P_WIDTH),
        .MUL_STAGES (MUL_STAGES)
    ) u_mul (
        .clk (clk),
        .ce  (ce),
        .a   (a_sel),
        .b   (b_sel),
        .p   (res_data)
    );

    assign stg_out       = stg_pipe[MUL_STAGES-1];
    assign res_valid     = stg_out.vld;
    assign res_tag       = stg_out.tag[TAG_W-1:0];
    assign unused_tag_hi = ^stg_out.tag;

    always_comb begin
        idle = 1'b1;
        for (int i = 0; i < MUL_STAGES; i++) if (stg_pipe[i].vld) idle = 1'b0;
    end

endmodule

// File: tb/tb_torgb_mul_arbiter.sv
// Scoreboarded random + directed bench for torgb_mul_arbiter.
module tb_torgb_mul_arbiter;

    localparam int NR = 3;
    localparam int AW = 32;
    localparam int BW = 34;
    localparam int PW = 65;
    localparam int MS = 1;
    localparam int TW = 2;

    typedef struct {
        int          tag;
        logic [PW-1:0] d;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [NR-1:0]     rv;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_a;
    logic [NR*BW-1:0]  req_b;
    logic              res_valid;
    logic              rrdy;
    logic [TW-1:0]     res_tag;
    logic [PW-1:0]     res_data;
    logic              idle;
    logic [31:0]       op_count;

    logic [AW-1:0]     a_arr [NR];
    logic [BW-1:0]     b_arr [NR];

    exp_t              sbq [$];
    int                gseq [$];
    int                total = 0;
    int                bad   = 0;

    // reference model state
    bit                mvld [MS];
    int                mrr;
    logic [31:0]       mcnt;

    torgb_mul_arbiter #(
        .NUM_REQ(NR), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .MUL_STAGES(MS), .TAG_W(TW)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .req_valid (rv),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (rrdy),
        .res_tag   (res_tag),
        .res_data  (res_data),
        .idle      (idle),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_a[i*AW +: AW] = a_arr[i];
            req_b[i*BW +: BW] = b_arr[i];
        end
    end

    function automatic logic [PW-1:0] ref_mul(input logic [AW-1:0] a, input logic [BW-1:0] b);
        logic [127:0] x, y, p;
        x = {{(128-AW){a[AW-1]}}, a};
        y = {{(128-BW){1'b0}}, b};
        p = x * y;
        return p[PW-1:0];
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic raise(input int i);
        if (!rv[i]) begin
            rv[i]    = 1'b1;
            a_arr[i] = $urandom;
            b_arr[i] = {2'($urandom_range(0, 3)), 32'($urandom)};
        end
    endtask

    // One cycle: inputs already driven after the falling edge.
    task automatic step();
        logic [NR-1:0] eg;
        int            ei, idx;
        bit            mrv, ce, midle;
        #2;
        mrv   = mvld[MS-1];
        ce    = !mrv || rrdy;
        midle = 1'b1;
        for (int i = 0; i < MS; i++) if (mvld[i]) midle = 1'b0;
        eg = '0;
        ei = -1;
        if (ce) begin
            for (int k = 0; k < NR; k++) begin
                idx = (mrr + k) % NR;
                if (ei < 0 && rv[idx]) ei = idx;
            end
        end
        if (ei >= 0) eg[ei] = 1'b1;
        chk("req_ready", req_ready, eg);
        chk("res_valid", res_valid, mrv);
        chk("idle", idle, midle);
        chk("op_count", op_count, mcnt);
        if (ei >= 0) begin
            sbq.push_back('{tag: ei, d: ref_mul(a_arr[ei], b_arr[ei])});
            gseq.push_back(ei);
            mrr  = (ei + 1) % NR;
            mcnt = mcnt + 32'd1;
        end
        if (ce) begin
            for (int i = MS-1; i > 0; i--) mvld[i] = mvld[i-1];
            mvld[0] = (ei >= 0);
        end
        @(negedge clk);
        if (ei >= 0) rv[ei] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rv    = '0;
        rrdy  = 1'b1;
        sbq.delete();
        mrr   = 0;
        mcnt  = '0;
        for (int i = 0; i < MS; i++) mvld[i] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_tag", res_tag, 0);
        chk("rst_idle", idle, 1);
        chk("rst_op_count", op_count, 0);
    endtask

    task automatic drain();
        rv   = '0;
        rrdy = 1'b1;
        repeat (MS + 3) step();
        chk("drain_empty", sbq.size(), 0);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && res_valid) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_result tag=%0d data=%0h exp=none", res_tag, res_data);
                end else begin
                    chk("res_tag", res_tag, sbq[0].tag);
                    chk("res_data", res_data, sbq[0].d);
                    if (rrdy) void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        rv    = '0;
        rrdy  = 1'b1;
        for (int i = 0; i < NR; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        do_reset();

        // single request from requester 1
        rv[1] = 1'b1; a_arr[1] = 32'hFFFF_FFFD; b_arr[1] = 34'd5;
        step();
        #1;
        chk("single_valid", res_valid, 1);
        chk("single_tag", res_tag, 1);
        chk("single_data", res_data, 65'h1_FFFF_FFFF_FFFF_FFF1);
        chk("single_count", op_count, 1);
        drain();

        // all requesting from reset: rotation with no bubbles
        do_reset();
        gseq.delete();
        repeat (6) begin
            for (int i = 0; i < NR; i++) raise(i);
            step();
        end
        chk("rr_count", gseq.size(), 6);
        for (int i = 0; i < gseq.size(); i++) chk("rr_order", gseq[i], i % NR);

        // backpressure with results pending
        rrdy = 1'b1;
        repeat (2) begin for (int i = 0; i < NR; i++) raise(i); step(); end
        rrdy = 1'b0;
        repeat (3) begin for (int i = 0; i < NR; i++) raise(i); step(); end
        rrdy = 1'b1;
        repeat (3) begin for (int i = 0; i < NR; i++) raise(i); step(); end
        drain();

        // operand extremes
        rv[0] = 1'b1; a_arr[0] = 32'h8000_0000; b_arr[0] = 34'h3_FFFF_FFFF;
        step();
        #1;
        chk("extreme_data", res_data, 65'h0_8000_0000);
        drain();

        // randomized traffic with random backpressure
        repeat (400) begin
            for (int i = 0; i < NR; i++) if ($urandom_range(0, 2) != 0) raise(i);
            rrdy = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        // counter wrap
        force dut.op_count = 32'hFFFF_FFFF;
        #1;
        release dut.op_count;
        mcnt = 32'hFFFF_FFFF;
        raise(2);
        step();
        #1;
        chk("op_count_wrap", op_count, 0);
        drain();

        // reset with one product in flight
        raise(0);
        step();
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_idle", idle, 1);
        chk("midrst_op_count", op_count, 0);
        do_reset();
        repeat (4) step();
        for (int i = 0; i < NR; i++) raise(i);
        #1;
        chk("post_reset_grant", req_ready, 3'b001);
        step();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
